// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
// Pure definitions: no latency, no flow control.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    localparam int unsigned DEF_RST_HOLD_CYC    = 64;
    localparam int unsigned DEF_LOCK_TIMEOUT    = 50000;
    localparam int unsigned DEF_LOCK_STABLE_CYC = 1024;
    localparam int unsigned DEF_MAX_RETRIES     = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reset value 0.
// Latency 2 clk edges; no flow control.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock, then releases sys_rst_n.
// All outputs registered (one edge after the deciding cycle); no flow control, relock_req always accepted.
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC    = DEF_RST_HOLD_CYC,
    parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       lock_lost,
    output logic       fail,
    output logic [2:0] state
);

    localparam int unsigned CNT_MAX = max3(RST_HOLD_CYC, LOCK_TIMEOUT, LOCK_STABLE_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);

    pll_state_t       cur_state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt, cnt_inc;
    logic [RTY_W-1:0] retry, nxt_retry, retry_inc;
    logic             locked_s;
    logic             lost_d;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign retry_inc = retry + RTY_W'(1);

    always_comb begin
        nxt_state = cur_state;
        nxt_cnt   = cnt_inc;
        nxt_retry = retry;
        lost_d    = 1'b0;
        if (relock_req) begin
            // A requested restart wins over everything, including a coincident lock loss.
            nxt_state = ST_RESET_PLL;
            nxt_cnt   = '0;
            nxt_retry = '0;
        end else begin
            case (cur_state)
                ST_RESET_PLL: begin
                    if (cnt == HOLD_LAST) begin
                        nxt_state = ST_WAIT_LOCK;
                        nxt_cnt   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        nxt_state = ST_STABLE;
                        nxt_cnt   = '0;
                    end else if (cnt == TMO_LAST) begin
                        nxt_retry = retry_inc;
                        nxt_cnt   = '0;
                        nxt_state = (retry_inc == RTY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        nxt_state = ST_WAIT_LOCK;
                        nxt_cnt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        nxt_state = ST_RUN;
                        nxt_cnt   = '0;
                        nxt_retry = '0;
                    end
                end
                ST_RUN: begin
                    nxt_cnt = '0;
                    if (!locked_s) begin
                        nxt_state = ST_RESET_PLL;
                        lost_d    = 1'b1;
                    end
                end
                ST_FAIL: begin
                    nxt_cnt = '0;
                end
                default: begin
                    nxt_state = ST_RESET_PLL;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_RESET_PLL;
            cnt       <= '0;
            retry     <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= nxt_cnt;
            retry     <= nxt_retry;
            pll_rst   <= (nxt_state == ST_RESET_PLL) || (nxt_state == ST_FAIL);
            sys_rst_n <= (nxt_state == ST_RUN);
            lock_lost <= lost_d;
            fail      <= (nxt_state == ST_FAIL);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed timing pins plus randomized lock/relock/reset traffic
// checked every cycle against a phase/elapsed-time model of the sequencing rules.
module tb_pll_reset_ctrl;

    localparam int HOLD = 4;
    localparam int TMO  = 20;
    localparam int STB  = 8;
    localparam int RTY  = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_lost;
    logic       fail;
    logic [2:0] state;

    always #5 refclk = ~refclk;

    pll_reset_ctrl #(
        .RST_HOLD_CYC    (HOLD),
        .LOCK_TIMEOUT    (TMO),
        .LOCK_STABLE_CYC (STB),
        .MAX_RETRIES     (RTY)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .lock_lost  (lock_lost),
        .fail       (fail),
        .state      (state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase number, cycles elapsed in the phase, failed attempts,
    // and the last two sampled lock values standing in for the synchroniser delay.
    int m_phase, m_cnt, m_retry;
    bit m_s0, m_s1, m_lost;

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_retry = 0;
        m_s0 = 0; m_s1 = 0; m_lost = 0;
    endtask

    task automatic model_step(input bit li, input bit rq);
        bit ls;
        ls = m_s1;
        m_s1 = m_s0;
        m_s0 = li;
        m_lost = 0;
        if (rq) begin
            m_phase = 0; m_cnt = 0; m_retry = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_cnt++;
                    if (m_cnt == HOLD) begin m_phase = 1; m_cnt = 0; end
                end
                1: begin
                    if (ls) begin
                        m_phase = 2; m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == TMO) begin
                            m_retry++;
                            m_cnt = 0;
                            m_phase = (m_retry == RTY) ? 4 : 0;
                        end
                    end
                end
                2: begin
                    if (!ls) begin
                        m_phase = 1; m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == STB) begin m_phase = 3; m_cnt = 0; m_retry = 0; end
                    end
                end
                3: if (!ls) begin m_phase = 0; m_lost = 1; end
                default: ;
            endcase
        end
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after each rising edge.
    always @(posedge refclk) begin
        #1;
        if (!rst_n) model_reset();
        else model_step(pll_locked, relock_req);
        check("cyc_state",     int'(state),     m_phase);
        check("cyc_pll_rst",   int'(pll_rst),   int'(m_phase == 0 || m_phase == 4));
        check("cyc_sys_rst_n", int'(sys_rst_n), int'(m_phase == 3));
        check("cyc_fail",      int'(fail),      int'(m_phase == 4));
        check("cyc_lock_lost", int'(lock_lost), int'(m_lost));
    end

    task automatic wait_state(input int st, input string name);
        int n = 0;
        while (int'(state) != st && n < 500) begin @(negedge refclk); n++; end
        check(name, int'(state), st);
    endtask

    task automatic run_len(input int st, output int n);
        n = 0;
        while (int'(state) == st && n < 500) begin @(negedge refclk); n++; end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_state"},     int'(state),     0);
        check({pfx, "_pll_rst"},   int'(pll_rst),   1);
        check({pfx, "_sys_rst_n"}, int'(sys_rst_n), 0);
        check({pfx, "_lock_lost"}, int'(lock_lost), 0);
        check({pfx, "_fail"},      int'(fail),      0);
    endtask

    initial begin
        int n;
        int run_left;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(negedge refclk);
        check_reset_vals("por");

        // Normal bring-up.
        rst_n = 1'b1;
        n = 0;
        while (pll_rst && n < 100) begin @(negedge refclk); n++; end
        check("pll_rst_hold", n, 4);
        repeat (4) @(negedge refclk);
        pll_locked = 1'b1;
        n = 0;
        while (int'(state) != 2 && n < 100) begin @(negedge refclk); n++; end
        check("lock_to_stable", n, 3);
        n = 0;
        while (!sys_rst_n && n < 100) begin @(negedge refclk); n++; end
        check("stable_to_run", n, 8);
        check("run_state", int'(state), 3);

        // Unrequested lock loss in RUN.
        repeat (3) @(negedge refclk);
        pll_locked = 1'b0;
        n = 0;
        while (int'(state) != 0 && n < 100) begin @(negedge refclk); n++; end
        check("lockloss_edges", n, 3);
        check("lockloss_pulse", int'(lock_lost), 1);
        check("lockloss_sysrst", int'(sys_rst_n), 0);
        @(negedge refclk);
        check("lockloss_single", int'(lock_lost), 0);

        // Two timeouts lead to FAIL.
        run_len(0, n);
        run_len(1, n);
        check("wait_win1", n, 20);
        run_len(0, n);
        check("retry_hold", n, 4);
        run_len(1, n);
        check("wait_win2", n, 20);
        check("fail_state", int'(state), 4);
        check("fail_flag", int'(fail), 1);
        repeat (10) @(negedge refclk);
        check("fail_held", int'(state), 4);
        check("fail_pll_rst", int'(pll_rst), 1);

        // Relock out of FAIL.
        pll_locked = 1'b1;
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        check("relock_fail_clr", int'(fail), 0);
        check("relock_state", int'(state), 0);
        wait_state(3, "relock_run");

        // Lock glitch during STABLE restarts the stability window.
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        wait_state(2, "glitch_enter_stable");
        repeat (3) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        wait_state(1, "glitch_back_wait");
        wait_state(2, "glitch_restable");
        run_len(2, n);
        check("fresh_stable_len", n, 8);
        check("fresh_run", int'(state), 3);

        // relock_req on the same edge that RUN sees the lock drop.
        repeat (2) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        check("coincide_no_lost", int'(lock_lost), 0);
        check("coincide_state", int'(state), 0);

        // Asynchronous reset mid-WAIT_LOCK and mid-RUN.
        wait_state(1, "pre_arst_wait");
        repeat (3) @(negedge refclk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("arst_wait");
        @(negedge refclk);
        rst_n = 1'b1;
        pll_locked = 1'b1;
        wait_state(3, "pre_arst_run");
        repeat (2) @(negedge refclk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("arst_run");
        @(negedge refclk);
        rst_n = 1'b1;

        // Randomized traffic, checked by the per-cycle compare.
        run_left = 0;
        repeat (4000) begin
            @(negedge refclk);
            if (run_left == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                run_left = $urandom_range(1, 40);
            end else begin
                run_left--;
            end
            relock_req = ($urandom_range(0, 79) == 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
        end
        @(negedge refclk);
        relock_req = 1'b0;
        rst_n = 1'b1;
        @(negedge refclk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
